// File: rtl/addr_buff_pkg.sv
// Shared types, default parameters and width helpers for the banked address-buffer reader.
package addr_buff_pkg;

  localparam int DEF_SRAM_DEPTH = 1024;
  localparam int DEF_BAND_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 10;

  localparam int FIFO_DEPTH = 3;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_state_e;

  function automatic int entry_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int bank_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

  // A bank count must be able to represent a completely full bank.
  function automatic int cnt_w(input int depth);
    return entry_w(depth) + 1;
  endfunction

  function automatic int addr_w(input int depth, input int banks);
    return entry_w(depth) + bank_w(banks);
  endfunction

endpackage

// File: rtl/addr_skid_fifo.sv
// Three-entry circular FIFO that absorbs read data while the downstream stream is stalled.
module addr_skid_fifo
  import addr_buff_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [W-1:0]          head,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [W-1:0]          mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  do_pop;

  function automatic logic [FIFO_PTR_W-1:0] ptr_inc(input logic [FIFO_PTR_W-1:0] p);
    return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
  endfunction

  assign valid  = (count != '0);
  assign head   = mem[rd_ptr];
  assign do_pop = pop && valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is cleared as well so the head, and hence the stream data, reads zero out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + FIFO_CNT_W'(1);
        2'b01:   count <= count - FIFO_CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/addr_buff_reader.sv
// Drains a banked address buffer: reads every valid entry bank by bank and streams the
// words downstream with their bank index, flagging the final word of the sweep.
module addr_buff_reader
  import addr_buff_pkg::*;
#(
  parameter int SRAM_DEPTH = DEF_SRAM_DEPTH,
  parameter int BAND_WIDTH = DEF_BAND_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          start,
  input  logic [BAND_WIDTH-1:0][cnt_w(SRAM_DEPTH)-1:0]  bank_cnt,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          enb,
  output logic [addr_w(SRAM_DEPTH, BAND_WIDTH)-1:0]     addrb,
  input  logic [DATA_WIDTH-1:0]                         dob,
  output logic                                          m_valid,
  input  logic                                          m_ready,
  output logic [DATA_WIDTH-1:0]                         m_data,
  output logic [bank_w(BAND_WIDTH)-1:0]                 m_bank,
  output logic                                          m_last
);

  localparam int EW = entry_w(SRAM_DEPTH);
  localparam int BW = bank_w(BAND_WIDTH);
  localparam int CW = cnt_w(SRAM_DEPTH);
  localparam int FW = DATA_WIDTH + BW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(SRAM_DEPTH);

  rd_state_e                     state;
  logic [BAND_WIDTH-1:0][CW-1:0] cnt_q;
  logic [BAND_WIDTH-1:0][CW-1:0] cnt_clamped;
  logic [BW-1:0]                 bank_q;
  logic [EW-1:0]                 entry_q;
  logic                          in_flight_q;
  logic [BW-1:0]                 fl_bank_q;
  logic                          fl_last_q;
  logic [FIFO_CNT_W-1:0]         fifo_count;
  logic                          pop;
  logic                          first_any, next_any, last_entry, drain_done;
  logic [BW-1:0]                 first_bank, next_bank;

  // Lowest bank at or above lo holding a nonzero count, with a found flag on top.
  function automatic logic [BW:0] find_bank(input logic [BAND_WIDTH-1:0][CW-1:0] cnts,
                                            input int lo);
    logic [BW:0] r;
    r = '0;
    for (int i = BAND_WIDTH - 1; i >= 0; i--)
      if (i >= lo && cnts[i] != '0) r = {1'b1, BW'(i)};
    return r;
  endfunction

  always_comb begin
    // NOTE: every always_comb output is fully assigned on each pass so no latch is inferred.
    cnt_clamped = '0;
    for (int i = 0; i < BAND_WIDTH; i++)
      cnt_clamped[i] = (bank_cnt[i] > DEPTH_C) ? DEPTH_C : bank_cnt[i];
  end

  assign {first_any, first_bank} = find_bank(cnt_clamped, 0);
  assign {next_any, next_bank}   = find_bank(cnt_q, int'(bank_q) + 1);
  assign last_entry = (({1'b0, entry_q} + CW'(1)) == cnt_q[bank_q]);

  // Throttle so that buffered words plus reads still in the RAM pipe never exceed the FIFO.
  assign enb   = (state == ST_READ) &&
                 (({1'b0, fifo_count} + {{FIFO_CNT_W{1'b0}}, in_flight_q}) < (FIFO_CNT_W + 1)'(FIFO_DEPTH));
  assign addrb = {bank_q, entry_q};
  assign pop   = m_valid && m_ready;
  assign drain_done = !in_flight_q &&
                      (fifo_count == '0 || (fifo_count == FIFO_CNT_W'(1) && pop));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt_q       <= '0;
      bank_q      <= '0;
      entry_q     <= '0;
      in_flight_q <= 1'b0;
      fl_bank_q   <= '0;
      fl_last_q   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register here sees pre-edge values.
      in_flight_q <= enb;
      fl_bank_q   <= bank_q;
      fl_last_q   <= enb && last_entry && !next_any;
      done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt_q <= cnt_clamped;
            if (first_any) begin
              state   <= ST_READ;
              busy    <= 1'b1;
              bank_q  <= first_bank;
              entry_q <= '0;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (enb) begin
            if (!last_entry) begin
              entry_q <= entry_q + EW'(1);
            end else if (next_any) begin
              bank_q  <= next_bank;
              entry_q <= '0;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_done) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          bank_q  <= '0;
          entry_q <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  addr_skid_fifo #(.W(FW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight_q),
    .push_data ({fl_last_q, fl_bank_q, dob}),
    .pop       (pop),
    .valid     (m_valid),
    .head      ({m_last, m_bank, m_data}),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_addr_buff_reader.sv
// Directed and randomized sweeps of addr_buff_reader against a RAM model and an
// expected-stream reference built from the bank counts.
module tb_addr_buff_reader;

  logic              clk = 1'b0;
  logic              rst, start, m_ready;
  logic [15:0][10:0] bank_cnt;
  logic              busy, done, enb, m_valid, m_last;
  logic [13:0]       addrb;
  logic [9:0]        dob, m_data;
  logic [3:0]        m_bank;

  logic [9:0] mem [16384];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  addr_buff_reader dut (
    .clk(clk), .rst(rst), .start(start), .bank_cnt(bank_cnt),
    .busy(busy), .done(done), .enb(enb), .addrb(addrb), .dob(dob),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_bank(m_bank), .m_last(m_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One start-to-done sweep. stall_from/to are cycles relative to the first m_valid
  // (-1 disables); abort_at > 0 resets the DUT (with start also high) after that many reads.
  task automatic sweep(input string tag, input int cnts[16], input int stall_from,
                       input int stall_to, input bit rand_ready, input int mid_start,
                       input int abort_at, input bit chk_rate);
    int          exp_addr[$];
    logic [14:0] exp_beat[$];
    logic [14:0] obs, prev_out, tmp;
    int          cyc, first_enb, first_valid, last_acc, enbs, beats, dones, tail, n, total;
    bit          prev_enb, prev_hold, aborted;
    logic [13:0] prev_addr;

    total = 0;
    for (int b = 0; b < 16; b++) begin
      n = (cnts[b] > 1024) ? 1024 : cnts[b];
      for (int e = 0; e < n; e++) begin
        exp_addr.push_back(b * 1024 + e);
        exp_beat.push_back({1'b0, 4'(b), mem[b * 1024 + e]});
      end
      total += n;
      bank_cnt[b] = 11'(cnts[b]);
    end
    if (total > 0) begin
      tmp = exp_beat[total - 1];
      tmp[14] = 1'b1;
      exp_beat[total - 1] = tmp;
    end

    cyc = 0; first_enb = -1; first_valid = -1; last_acc = -1;
    enbs = 0; beats = 0; dones = 0; tail = 0;
    prev_enb = 1'b0; prev_hold = 1'b0; aborted = 1'b0;
    prev_addr = '0; prev_out = '0;

    @(negedge clk);
    start = 1'b1; m_ready = 1'b1; dob = 10'($urandom);
    while (tail < 3 && cyc < 4000 && !aborted) begin
      @(negedge clk);
      cyc++;
      start = (cyc == mid_start);
      dob   = prev_enb ? mem[prev_addr] : 10'($urandom);
      if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
      else m_ready = !(stall_from >= 0 && first_valid >= 0 &&
                       cyc >= first_valid + stall_from && cyc <= first_valid + stall_to);
      obs = {m_last, m_bank, m_data};

      if (cyc == 1) check({tag, ":busy_after_start"}, 32'(busy), 32'(total > 0));
      if (enb) begin
        enbs++;
        if (first_enb < 0) begin
          first_enb = cyc;
          check({tag, ":first_enb_cycle"}, 32'(cyc), 32'd1);
        end
        check({tag, ":enb_expected"}, 32'(exp_addr.size() > 0), 32'd1);
        if (exp_addr.size() > 0) check({tag, ":addrb"}, 32'(addrb), 32'(exp_addr.pop_front()));
        check({tag, ":outstanding_le3"}, 32'((enbs - beats) <= 3), 32'd1);
      end
      if (prev_hold) check({tag, ":hold_stable"}, {16'd0, m_valid, obs}, {16'd0, 1'b1, prev_out});
      if (m_valid) begin
        if (first_valid < 0) begin
          first_valid = cyc;
          check({tag, ":first_valid_cycle"}, 32'(cyc), 32'(first_enb + 2));
        end
        check({tag, ":beat_expected"}, 32'(exp_beat.size() > 0), 32'd1);
        if (exp_beat.size() > 0) begin
          if (m_ready) begin
            check({tag, ":beat"}, 32'(obs), 32'(exp_beat.pop_front()));
            beats++;
            last_acc = cyc;
          end else begin
            check({tag, ":beat_stalled"}, 32'(obs), 32'(exp_beat[0]));
          end
        end
      end
      prev_hold = m_valid && !m_ready;
      prev_out  = obs;
      if (done) begin
        dones++;
        check({tag, ":done_cycle"}, 32'(cyc), 32'((last_acc < 0) ? 1 : last_acc + 1));
        check({tag, ":busy_in_done"}, 32'(busy), 32'd0);
      end
      if (dones > 0) tail++;
      prev_enb  = enb;
      prev_addr = addrb;
      if (abort_at > 0 && enbs == abort_at) begin
        rst = 1'b1; start = 1'b1; aborted = 1'b1;
      end
    end

    if (aborted) begin
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      dob = prev_enb ? mem[prev_addr] : 10'($urandom);
      check({tag, ":rst_ctrl_zero"}, {27'd0, busy, done, enb, m_valid, m_last}, 32'd0);
      check({tag, ":rst_data_zero"}, {4'd0, addrb, m_data, m_bank}, 32'd0);
      repeat (4) begin
        @(negedge clk);
        dob = 10'($urandom);
        check({tag, ":post_abort_quiet"}, {28'd0, busy, done, enb, m_valid}, 32'd0);
      end
    end else begin
      check({tag, ":reads_left"}, 32'(exp_addr.size()), 32'd0);
      check({tag, ":beats_left"}, 32'(exp_beat.size()), 32'd0);
      check({tag, ":done_count"}, 32'(dones), 32'd1);
      if (chk_rate) check({tag, ":one_per_cycle"}, 32'(last_acc - first_valid + 1), 32'(beats));
    end
  endtask

  initial begin
    int c[16];
    for (int i = 0; i < 16384; i++) mem[i] = 10'($urandom);
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; bank_cnt = '0; dob = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {27'd0, busy, done, enb, m_valid, m_last}, 32'd0);
    check("reset_data", {4'd0, addrb, m_data, m_bank}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    c = '{default: 0}; c[0] = 3;
    sweep("bank0x3", c, -1, -1, 1'b0, -1, 0, 1'b1);

    c = '{default: 0}; c[2] = 1; c[5] = 2;
    sweep("bank2_5", c, -1, -1, 1'b0, -1, 0, 1'b1);

    c = '{default: 0}; c[0] = 8;
    sweep("stall", c, 3, 6, 1'b0, -1, 0, 1'b0);

    c = '{default: 0};
    sweep("all_zero", c, -1, -1, 1'b0, -1, 0, 1'b0);

    c = '{default: 0}; c[15] = 1024;
    sweep("bank15_full", c, -1, -1, 1'b0, 100, 0, 1'b1);

    c = '{default: 0}; c[1] = 2; c[3] = 1500;
    sweep("clamp", c, -1, -1, 1'b0, -1, 0, 1'b1);

    c = '{default: 0}; c[0] = 10;
    sweep("abort", c, -1, -1, 1'b0, -1, 5, 1'b0);
    sweep("after_abort", c, -1, -1, 1'b0, -1, 0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 16; b++) c[b] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 5)) : 0;
      sweep($sformatf("rand%0d", r), c, -1, -1, 1'b1, 7, 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/addr_buff_reader.md
ADDR_BUFF_READER -- requirements
Module: addr_buff_reader

Interface
REQ-001 SHALL have parameter SRAM_DEPTH, 1024, entries per bank.
REQ-002 SHALL have parameter BAND_WIDTH, 16, number of banks.
REQ-003 SHALL have parameter DATA_WIDTH, 10, stored address-word width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to drain the banked buffer.
REQ-007 SHALL have port bank_cnt  input  [BAND_WIDTH] x ($clog2(SRAM_DEPTH)+1)  valid entries per bank.
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the last element is accepted downstream.
REQ-010 SHALL have port enb  output  1  buffer read enable.
REQ-011 SHALL have port addrb  output  $clog2(SRAM_DEPTH)+$clog2(BAND_WIDTH)  {bank, entry} read address.
REQ-012 SHALL have port dob  input  DATA_WIDTH  buffer read data, valid one cycle after enb.
REQ-013 SHALL have ports m_valid output 1, m_ready input 1, m_data output DATA_WIDTH, m_bank output $clog2(BAND_WIDTH), m_last output 1: downstream stream.

Function
REQ-014 SHALL accept start only in IDLE; start while busy is ignored.
REQ-015 SHALL latch bank_cnt on accepted start; counts above SRAM_DEPTH clamp to SRAM_DEPTH.
REQ-016 SHALL use FSM IDLE -> READ (start, any count nonzero) -> DRAIN (last read issued) -> DONE (FIFO empty, nothing in flight) -> IDLE; start with all counts zero goes IDLE -> DONE.
REQ-017 SHALL read banks in ascending index, entries 0..cnt-1 per bank, skipping zero-count banks with no bubble cycle.
REQ-018 SHALL issue at most one enb per cycle, only in READ, only when FIFO occupancy + in-flight reads < 3 (registered values).
REQ-019 SHALL capture dob into a 3-entry FIFO the cycle after enb; FIFO head drives m_data/m_bank/m_last.
REQ-020 SHALL issue the first enb in the cycle after start; first m_valid two cycles after first enb.
REQ-021 SHALL sustain one element per cycle while m_ready is held high.
REQ-022 SHALL hold m_valid, m_data, m_bank, m_last stable while m_valid && !m_ready.
REQ-023 SHALL assert m_last only with the final element of the whole sweep.
REQ-024 SHALL assert done for exactly one cycle in DONE; busy low in that cycle.

Reset
REQ-025 SHALL, on rst, force IDLE, clear FIFO, in-flight flag and counters; busy, done, enb, m_valid, m_last = 0; addrb, m_data, m_bank = 0.
REQ-026 SHALL treat rst mid-sweep as abort: dob arriving the cycle after rst is discarded; no done pulse.
REQ-027 SHALL treat rst as having priority over start in the same cycle.

Structure
REQ-028 SHALL place state enum, default parameters and address-width helpers in shared package addr_buff_pkg.
REQ-029 SHALL implement the 3-entry FIFO as sub-module addr_skid_fifo.

Verification
REQ-030 Counts bank0=3, others 0, m_ready=1 -> addrb 0,1,2 on consecutive cycles; three beats m_bank=0, m_last on third; done one cycle after.
REQ-031 Counts bank2=1, bank5=2, others 0 -> addrb 0x800, 0x1400, 0x1401 back-to-back; m_bank 2,5,5.
REQ-032 Counts bank0=8, m_ready low cycles 3-6 after first m_valid -> no more than 3 outstanding, data held stable, all 8 values in order, no loss.
REQ-033 All counts zero, start -> no enb, no m_valid, done pulses cycle after start.
REQ-034 bank15=1024, m_ready=1 -> 1024 beats at 1/cycle, last addrb 0x3FFF; start pulse mid-sweep ignored.
REQ-035 rst asserted after 5 of 10 reads -> all outputs zero next cycle, no done; new start sweeps cleanly from entry 0.
